uart_rx_cfg: RTL and testbench
==============================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning data bits per frame (legal 5..9).
REQ-002 The block SHALL have parameter OVERSAMPLE, default 16, meaning i_tick pulses per bit period (legal 8..64, even).
REQ-003 The block SHALL have parameter PARITY_MODE, default 1, meaning 0 = none, 1 = even, 2 = odd.
REQ-004 The block SHALL have parameter STOP_WIDTH, default 1, meaning stop bits per frame (1 or 2).
REQ-005 The block SHALL have port i_clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port i_reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port i_tick, input, 1 bit: oversampling strobe, one-cycle pulse.
REQ-008 The block SHALL have port i_rx, input, 1 bit: asynchronous serial line, idle high.
REQ-009 The block SHALL have port o_data, output, DATA_WIDTH bits: received word, LSB first on the line.
REQ-010 The block SHALL have port o_valid, output, 1 bit: o_data and the error flags are valid.
REQ-011 The block SHALL have port i_ready, input, 1 bit: consumer accepts the word.
REQ-012 The block SHALL have port o_parity_err, output, 1 bit: parity mismatch for the held word (always 0 when PARITY_MODE=0).
REQ-013 The block SHALL have port o_frame_err, output, 1 bit: a stop bit was sampled low for the held word.
REQ-014 The block SHALL have port o_overrun, output, 1 bit: sticky; a completed word was discarded.
REQ-015 The block SHALL have port o_busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-016 i_rx SHALL pass through a 2-flop synchroniser; all decisions SHALL use the synchronised value, giving 2 cycles of input latency.
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY, STOP and BREAK_WAIT; PARITY SHALL be skipped when PARITY_MODE=0.
REQ-018 IDLE SHALL move to START on a synchronised low, clearing the tick counter, the bit index and the shift register.
REQ-019 In START, on the i_tick that brings the counter to OVERSAMPLE/2-1, the FSM SHALL go to DATA if the line is low (counter cleared) and otherwise SHALL return to IDLE (glitch rejected, no output).
REQ-020 In DATA, PARITY and STOP, the counter SHALL increment per i_tick and wrap at OVERSAMPLE-1; the line SHALL be sampled on ticks at counts OVERSAMPLE-3, OVERSAMPLE-2 and OVERSAMPLE-1.
REQ-021 The bit value SHALL be the 2-of-3 majority of those samples, committed on the tick at count OVERSAMPLE-1.
REQ-022 DATA SHALL shift in exactly DATA_WIDTH bits, LSB first, then move to PARITY or STOP.
REQ-023 The parity error SHALL be computed as (XOR of data bits) XOR (parity bit) XOR (PARITY_MODE==2); nonzero SHALL set the error.
REQ-024 STOP SHALL sample STOP_WIDTH bits; any low stop bit SHALL set the frame error.
REQ-025 A frame SHALL complete on the last stop-bit commit; the result SHALL be registered and o_valid SHALL rise on the following clock.
REQ-026 After completion the FSM SHALL go to IDLE if the last stop bit was high, and otherwise to BREAK_WAIT.
REQ-027 BREAK_WAIT SHALL stay until the line is sampled high, then go to IDLE; no start SHALL be detected while in BREAK_WAIT.
REQ-028 o_data, o_parity_err, o_frame_err and o_valid SHALL hold until the cycle where o_valid && i_ready; o_valid SHALL drop on the next clock.
REQ-029 If a frame completes while o_valid=1 and i_ready=0, the new word SHALL be discarded, the held word kept and o_overrun set.
REQ-030 If completion and the handshake occur in the same cycle, the new word SHALL be loaded, o_valid SHALL stay 1 and no overrun SHALL be flagged.
REQ-031 o_overrun SHALL clear on the cycle after the next handshake.
REQ-032 i_tick SHALL be ignored in IDLE and BREAK_WAIT.

Reset
REQ-033 Asserting i_reset_n=0 SHALL immediately force IDLE, counters to 0, synchroniser flops to 1, o_data=0, and o_valid, o_parity_err, o_frame_err, o_overrun and o_busy to 0.
REQ-034 Reset mid-frame SHALL discard the partial word; after deassertion, reception SHALL resume only on a new start edge.

Verification (defaults, i_tick every 4 clocks)
REQ-035 The bench SHALL cover: send 0xA5 with even parity bit 0 and a good stop, i_ready=1 -> o_data=0xA5, o_valid high for 1 cycle, both error flags 0.
REQ-036 The bench SHALL cover: send 0x01 with parity bit 0 -> o_data=0x01, o_parity_err=1; with PARITY_MODE=2 and parity bit 0 -> o_parity_err=0.
REQ-037 The bench SHALL cover: a low pulse of 5 ticks on idle i_rx -> no o_valid and FSM back in IDLE; a single-tick glitch inside a data bit -> the majority vote yields the correct bit.
REQ-038 The bench SHALL cover: 0x3C with stop low, line then held low for 20 bit times -> o_frame_err=1, o_busy high until the line goes high, no spurious second word.
REQ-039 The bench SHALL cover: frames 0x11 then 0x22 with i_ready=0 -> o_data stays 0x11 and o_overrun=1; then i_ready=1 -> handshake, with o_overrun=0 on the next cycle.
REQ-040 The bench SHALL cover: i_reset_n pulsed low during data bit 4 -> all outputs 0 at once; the next full frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Oversampled UART receiver: 2-flop line synchroniser, 2-of-3 majority bit voting,
// optional parity, 1 or 2 stop bits, break hold-off and a valid/ready output register.
module uart_rx_cfg #(
   parameter int DATA_WIDTH  = 8,
   parameter int OVERSAMPLE  = 16,
   parameter int PARITY_MODE = 1,
   parameter int STOP_WIDTH  = 1
) (
   input  logic                  i_clock,
   input  logic                  i_reset_n,
   input  logic                  i_tick,
   input  logic                  i_rx,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic                  o_parity_err,
   output logic                  o_frame_err,
   output logic                  o_overrun,
   output logic                  o_busy,
   output logic [2:0]            o_dbg_state
);

   // Handshake: o_data and both error flags are stable while o_valid=1; a word is
   // consumed on any rising edge where o_valid && i_ready, and o_valid falls next clock.

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int IW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] C_HALF = CW'(OVERSAMPLE/2 - 1);
   localparam logic [CW-1:0] C_S0   = CW'(OVERSAMPLE - 3);
   localparam logic [CW-1:0] C_S1   = CW'(OVERSAMPLE - 2);
   localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } state_t;

   state_t                r_state;
   logic [1:0]            r_sync;
   logic [CW-1:0]         r_cnt;
   logic [IW-1:0]         r_bit_idx;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [1:0]            r_samp;
   logic                  r_par_bit;
   logic                  r_ferr_acc;
   logic                  r_done;
   logic [DATA_WIDTH-1:0] r_res_data;
   logic                  r_res_perr;
   logic                  r_res_ferr;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid;
   logic                  r_perr;
   logic                  r_ferr;
   logic                  r_overrun;

   logic          w_rx;
   logic [CW-1:0] w_cnt_nxt;
   logic          w_maj;
   logic          w_perr;

   assign w_rx      = r_sync[1];
   assign w_cnt_nxt = (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;
   // The third vote is the live sample taken on the committing tick itself.
   assign w_maj     = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_rx) | (r_samp[1] & w_rx);
   assign w_perr    = (PARITY_MODE == 0) ? 1'b0
                    : ((^r_shift) ^ r_par_bit ^ (PARITY_MODE == 2));

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_sync     <= 2'b11;
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
         r_samp     <= 2'b11;
         r_par_bit  <= 1'b0;
         r_ferr_acc <= 1'b0;
         r_done     <= 1'b0;
         r_res_data <= '0;
         r_res_perr <= 1'b0;
         r_res_ferr <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], i_rx};
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (!w_rx) begin
                  r_state    <= S_START;
                  r_cnt      <= '0;
                  r_bit_idx  <= '0;
                  r_shift    <= '0;
                  r_ferr_acc <= 1'b0;
               end
            end
            S_START: begin
               if (i_tick) begin
                  if (w_cnt_nxt == C_HALF) begin
                     r_cnt   <= '0;
                     r_state <= w_rx ? S_IDLE : S_DATA;
                  end else begin
                     r_cnt <= w_cnt_nxt;
                  end
               end
            end
            S_DATA, S_PARITY, S_STOP: begin
               if (i_tick) begin
                  r_cnt <= w_cnt_nxt;
                  if (w_cnt_nxt == C_S0) r_samp[0] <= w_rx;
                  if (w_cnt_nxt == C_S1) r_samp[1] <= w_rx;
                  if (w_cnt_nxt == C_LAST) begin
                     if (r_state == S_DATA) begin
                        r_shift <= {w_maj, r_shift[DATA_WIDTH-1:1]};
                        if (r_bit_idx == IW'(DATA_WIDTH - 1)) begin
                           r_bit_idx <= '0;
                           r_state   <= (PARITY_MODE == 0) ? S_STOP : S_PARITY;
                        end else begin
                           r_bit_idx <= r_bit_idx + 1'b1;
                        end
                     end else if (r_state == S_PARITY) begin
                        r_par_bit <= w_maj;
                        r_bit_idx <= '0;
                        r_state   <= S_STOP;
                     end else begin
                        r_ferr_acc <= r_ferr_acc | ~w_maj;
                        if (r_bit_idx == IW'(STOP_WIDTH - 1)) begin
                           r_done     <= 1'b1;
                           r_res_data <= r_shift;
                           r_res_perr <= w_perr;
                           r_res_ferr <= r_ferr_acc | ~w_maj;
                           r_bit_idx  <= '0;
                           r_state    <= w_maj ? S_IDLE : S_BREAK;
                        end else begin
                           r_bit_idx <= r_bit_idx + 1'b1;
                        end
                     end
                  end
               end
            end
            S_BREAK: begin
               if (w_rx) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // A word completing while the previous one is still unaccepted is dropped.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_perr    <= 1'b0;
         r_ferr    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (r_done && (!r_valid || i_ready)) begin
            r_data  <= r_res_data;
            r_perr  <= r_res_perr;
            r_ferr  <= r_res_ferr;
            r_valid <= 1'b1;
         end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
         end
         if (r_valid && i_ready) r_overrun <= 1'b0;
         else if (r_done && r_valid) r_overrun <= 1'b1;
      end
   end

   assign o_data       = r_data;
   assign o_valid      = r_valid;
   assign o_parity_err = r_perr;
   assign o_frame_err  = r_ferr;
   assign o_overrun    = r_overrun;
   assign o_busy       = (r_state != S_IDLE);
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: frames are driven bit-by-bit, a word-level model
// queue predicts each delivered word and one compare process checks it every cycle.
module tb_uart_rx_cfg;

   localparam int BIT_CLKS = 64;  // 16 ticks per bit, one tick every 4 clocks

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0;
   logic       rx = 1'b1;
   logic       ready = 1'b1;
   logic [7:0] data;
   logic       valid, perr, ferr, ovr, busy;
   logic [2:0] dbg;
   logic [7:0] o2_data;
   logic       o2_valid, o2_perr, o2_ferr, o2_ovr, o2_busy;
   logic [2:0] o2_dbg;

   logic [9:0] exp_q[$];
   int         n_tests = 0;
   int         n_fail = 0;
   bit         prev_hs = 1'b0;
   int         valid_cycles = 0;
   logic [7:0] last_data = '0;
   logic       last_perr = 1'b0;
   logic       last_ferr = 1'b0;
   logic [7:0] odd_last_data = '0;
   logic       odd_last_perr = 1'b1;
   int         v0;

   always #5 clk = ~clk;

   uart_rx_cfg dut (
      .i_clock(clk), .i_reset_n(rst_n), .i_tick(tick), .i_rx(rx),
      .o_data(data), .o_valid(valid), .i_ready(ready),
      .o_parity_err(perr), .o_frame_err(ferr), .o_overrun(ovr),
      .o_busy(busy), .o_dbg_state(dbg)
   );

   uart_rx_cfg #(.PARITY_MODE(2)) dut_odd (
      .i_clock(clk), .i_reset_n(rst_n), .i_tick(tick), .i_rx(rx),
      .o_data(o2_data), .o_valid(o2_valid), .i_ready(1'b1),
      .o_parity_err(o2_perr), .o_frame_err(o2_ferr), .o_overrun(o2_ovr),
      .o_busy(o2_busy), .o_dbg_state(o2_dbg)
   );

   // Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
   initial begin
      int k;
      k = 0;
      forever begin
         @(posedge clk);
         #1;
         k++;
         tick = (k % 4 == 0);
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_hs = 1'b0;
      end else begin
         if (prev_hs) begin
            n_tests++;
            if (ovr !== 1'b0 || (exp_q.size() == 0 && valid !== 1'b0)) begin
               n_fail++;
               $display("FAIL post_handshake: got valid=%0b overrun=%0b, required valid=0 overrun=0",
                        valid, ovr);
            end
         end
         if (valid) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_word: got data=%02h perr=%0b ferr=%0b, required no valid word",
                        data, perr, ferr);
            end else if ({perr, ferr, data} !== exp_q[0]) begin
               n_fail++;
               $display("FAIL word: got data=%02h perr=%0b ferr=%0b, required data=%02h perr=%0b ferr=%0b",
                        data, perr, ferr, exp_q[0][7:0], exp_q[0][9], exp_q[0][8]);
            end
         end
         prev_hs = valid && ready;
         if (prev_hs && exp_q.size() > 0) void'(exp_q.pop_front());
      end
   end

   always @(negedge clk) begin
      if (valid) begin
         valid_cycles++;
         last_data = data;
         last_perr = perr;
         last_ferr = ferr;
      end
      if (o2_valid) begin
         odd_last_data = o2_data;
         odd_last_perr = o2_perr;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end of test, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input int got, input int want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, got, want);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input bit glitch);
      rx = b;
      if (glitch) begin
         cyc(16);
         rx = ~b;
         cyc(4);
         rx = b;
         cyc(BIT_CLKS - 20);
      end else begin
         cyc(BIT_CLKS);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stopb, input int gidx);
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i], i == gidx);
      send_bit(pbit, 1'b0);
      send_bit(stopb, 1'b0);
   endtask

   // Model: under even parity, an error means data+parity bit hold an odd number of ones.
   task automatic push_exp(input logic [7:0] d, input logic pbit, input logic stopb);
      logic pe;
      pe = ($countones({d, pbit}) % 2) == 1;
      exp_q.push_back({pe, ~stopb, d});
   endtask

   function automatic logic even_bit(input logic [7:0] d);
      return ($countones(d) % 2) == 1;
   endfunction

   task automatic drain(input string name);
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) cyc(1);
      check(name, exp_q.size(), 0);
   endtask

   task automatic good_frame(input logic [7:0] d, input int gidx);
      push_exp(d, even_bit(d), 1'b1);
      send_frame(d, even_bit(d), 1'b1, gidx);
      cyc(2 * BIT_CLKS);
   endtask

   initial begin
      cyc(3);
      check("reset_data", data, 0);
      check("reset_valid", valid, 0);
      check("reset_perr", perr, 0);
      check("reset_ferr", ferr, 0);
      check("reset_overrun", ovr, 0);
      check("reset_busy", busy, 0);
      rst_n = 1'b1;
      cyc(10);
      check("idle_busy", busy, 0);

      v0 = valid_cycles;
      good_frame(8'hA5, -1);
      drain("drain_a5");
      check("a5_data", last_data, 8'hA5);
      check("a5_perr", last_perr, 0);
      check("a5_ferr", last_ferr, 0);
      check("a5_valid_cycles", valid_cycles - v0, 1);

      push_exp(8'h01, 1'b0, 1'b1);
      send_frame(8'h01, 1'b0, 1'b1, -1);
      cyc(2 * BIT_CLKS);
      drain("drain_01");
      check("01_data", last_data, 8'h01);
      check("01_perr_even", last_perr, 1);
      check("01_data_odd", odd_last_data, 8'h01);
      check("01_perr_odd", odd_last_perr, 0);

      v0 = valid_cycles;
      rx = 1'b0;
      cyc(12);
      check("start_glitch_busy", busy, 1);
      cyc(8);
      rx = 1'b1;
      cyc(40);
      check("start_glitch_idle", busy, 0);
      check("start_glitch_state", dbg, 0);
      check("start_glitch_no_word", valid_cycles - v0, 0);

      good_frame(8'hC3, 3);
      drain("drain_c3");
      check("c3_majority_data", last_data, 8'hC3);

      v0 = valid_cycles;
      push_exp(8'h3C, even_bit(8'h3C), 1'b0);
      send_frame(8'h3C, even_bit(8'h3C), 1'b0, -1);
      cyc(10 * BIT_CLKS);
      check("break_busy_mid", busy, 1);
      cyc(10 * BIT_CLKS);
      check("break_busy_end", busy, 1);
      check("break_data", last_data, 8'h3C);
      check("break_ferr", last_ferr, 1);
      check("break_one_word", valid_cycles - v0, 1);
      rx = 1'b1;
      for (int i = 0; i < 10 && busy; i++) cyc(1);
      check("break_release", busy, 0);
      cyc(2 * BIT_CLKS);
      check("break_no_second_word", valid_cycles - v0, 1);

      ready = 1'b0;
      push_exp(8'h11, even_bit(8'h11), 1'b1);
      send_frame(8'h11, even_bit(8'h11), 1'b1, -1);
      cyc(2 * BIT_CLKS);
      send_frame(8'h22, even_bit(8'h22), 1'b1, -1);
      cyc(2 * BIT_CLKS);
      check("ovr_held_data", data, 8'h11);
      check("ovr_valid", valid, 1);
      check("ovr_flag", ovr, 1);
      ready = 1'b1;
      cyc(1);
      check("ovr_clear", ovr, 0);
      check("ovr_valid_drop", valid, 0);
      drain("drain_ovr");

      rx = 1'b0;
      cyc(BIT_CLKS);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
      rx = 1'b0;
      cyc(20);
      rst_n = 1'b0;
      #1;
      check("midreset_data", data, 0);
      check("midreset_valid", valid, 0);
      check("midreset_perr", perr, 0);
      check("midreset_ferr", ferr, 0);
      check("midreset_overrun", ovr, 0);
      check("midreset_busy", busy, 0);
      rx = 1'b1;
      cyc(4);
      rst_n = 1'b1;
      cyc(2 * BIT_CLKS);
      check("postreset_idle", busy, 0);

      v0 = valid_cycles;
      good_frame(8'h5A, -1);
      drain("drain_5a");
      check("5a_data", last_data, 8'h5A);
      check("5a_perr", last_perr, 0);
      check("5a_ferr", last_ferr, 0);
      check("5a_one_word", valid_cycles - v0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
